// File: rtl/reg_file_master.sv
// rtl/reg_file_master.sv - burst command master driving a simple register file port
// Write bursts stream wdat beats straight to the file; read bursts fetch one word per beat.

module reg_file_master #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDR  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [ADDR-1:0]  cmd_len,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [WIDTH-1:0] wdat_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic             WrEn,
  output logic             RdEn,
  input  logic [WIDTH-1:0] RdData,
  output logic             busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RDW  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]      state;
  logic [ADDR-1:0] addr;
  logic [ADDR:0]   count;      // remaining beats, one bit wider so 8 beats fit
  logic [ADDR-1:0] addr_next;
  logic            last_beat;

  assign addr_next = (addr == ADDR'(DEPTH - 1)) ? '0 : addr + 1'b1;
  assign last_beat = (count == {{ADDR{1'b0}}, 1'b1});

  // Strobes are gated by rst so nothing reaches the file in the reset cycle itself.
  assign cmd_ready  = (state == S_IDLE) && !rst;
  assign wdat_ready = (state == S_WR) && !rst;
  assign WrEn       = wdat_ready && wdat_valid;
  assign RdEn       = (state == S_RD) && !rst;
  assign Address    = rst ? '0 : addr;
  assign WrData     = wdat_data;
  assign busy       = (state != S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      count     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr  <= cmd_addr;
            count <= {1'b0, cmd_len} + {{ADDR{1'b0}}, 1'b1};
            state <= cmd_op ? S_RD : S_WR;
          end
        end
        S_WR: begin
          if (wdat_valid) begin
            count <= count - 1'b1;
            if (last_beat) state <= S_IDLE;
            else           addr  <= addr_next;
          end
        end
        S_RD: state <= S_RDW;
        S_RDW: begin
          rsp_data  <= RdData;
          rsp_last  <= last_beat;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (last_beat) begin
              state <= S_IDLE;
            end else begin
              count <= count - 1'b1;
              addr  <= addr_next;
              state <= S_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_file_master.md
REG_FILE_MASTER -- requirements
Module: reg_file_master

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the register file data width.
REQ-002 SHALL have parameter DEPTH, default 8, the register file entry count.
REQ-003 SHALL have parameter ADDR, default 3, the register file address width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when both high.
REQ-008 cmd_op  input  1  0 = burst write, 1 = burst read.
REQ-009 cmd_addr  input  ADDR  start address.
REQ-010 cmd_len  input  ADDR  beat count minus 1 (0 gives 1 beat, 7 gives 8 beats).
REQ-011 wdat_valid  input  1  write beat offered.
REQ-012 wdat_ready  output  1  write beat consumed when both high.
REQ-013 wdat_data  input  WIDTH  write beat data.
REQ-014 rsp_valid  output  1  read beat available.
REQ-015 rsp_ready  input  1  read beat consumed when both high.
REQ-016 rsp_data  output  WIDTH  read beat data.
REQ-017 rsp_last  output  1  final beat of the burst; qualified by rsp_valid.
REQ-018 Address  output  ADDR  register file address.
REQ-019 WrData  output  WIDTH  register file write data.
REQ-020 WrEn  output  1  register file write strobe.
REQ-021 RdEn  output  1  register file read strobe.
REQ-022 RdData  input  WIDTH  register file read data; valid the cycle after a RdEn cycle.
REQ-023 busy  output  1  high whenever state is not IDLE.

Function
REQ-024 SHALL implement FSM states IDLE, WR, RD, RDW, RESP.
REQ-025 IDLE: cmd_ready = 1 (0 while rst high); on handshake, latch addr/len/op; next state is WR (op 0) or RD (op 1).
REQ-026 WR: wdat_ready = 1; WrEn = wdat_valid; Address = current address; WrData = wdat_data.
REQ-027 WR beat (wdat_valid high): address increments modulo DEPTH (7 wraps to 0) and remaining beats decrement; the last beat returns to IDLE.
REQ-028 WR with wdat_valid low: WrEn = 0; state, address and count hold; no timeout.
REQ-029 RD: RdEn = 1 for exactly one cycle with Address = current address; next state RDW.
REQ-030 RDW: RdEn = 0; capture RdData into rsp_data at cycle end; set rsp_last if this is the final beat; next state RESP.
REQ-031 RESP: rsp_valid = 1; rsp_data and rsp_last stable until rsp_ready.
REQ-032 RESP on handshake: if last beat, next state IDLE; otherwise increment address modulo DEPTH and go to RD.
REQ-033 Read latency: first rsp_valid in the 3rd cycle after the cmd handshake edge; minimum 3 cycles per read beat.
REQ-034 WrEn and RdEn SHALL never be high in the same cycle; both low in IDLE, RDW and RESP.
REQ-035 Address SHALL hold its last value outside WR and RD; WrData = wdat_data in all states.
REQ-036 wdat_ready SHALL be 0 outside WR; cmd_ready SHALL be 0 outside IDLE (no command queuing).
REQ-037 Beats counter SHALL be ADDR+1 bits wide so a len-8 burst is counted without overflow.

Reset
REQ-038 rst high at a clock edge SHALL force IDLE, address 0, count 0, rsp_valid 0, rsp_data 0, rsp_last 0.
REQ-039 During and after reset: WrEn = 0, RdEn = 0, Address = 0, busy = 0.
REQ-040 Reset mid-burst SHALL abandon the burst with no further WrEn/RdEn; register file contents are not touched by this block.

Verification
REQ-041 Write cmd addr 2, len 2, data 0x1111/0x2222/0x3333 back-to-back -> WrEn for 3 consecutive cycles at Address 2, 3, 4; then IDLE, cmd_ready = 1.
REQ-042 Read cmd addr 6, len 3 on a file holding 0xA006/0xA007/0xA000/0xA001 -> rsp_data sequence 0xA006, 0xA007, 0xA000, 0xA001 (wrap 7 to 0); rsp_last only on 0xA001.
REQ-043 Read len 0 with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable all 5 cycles; single RdEn pulse; IDLE one cycle after the handshake.
REQ-044 Write burst with wdat_valid gapped (1,0,0,1) -> exactly 2 WrEn pulses, at consecutive addresses, on the valid cycles only.
REQ-045 rst asserted in the cycle after the 2nd of 4 write beats -> no further WrEn, busy = 0 next cycle, a new command accepted after rst drops.
REQ-046 All tests: assertion that WrEn and RdEn are never both high, and cmd_ready is never high while busy.
